// File: rtl/wb_regfile.sv
// Writeback-stage register bank: writeback select, two bypassed read ports,
// and a handshaked engine that streams every register out for debug.
module wb_regfile #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_ADDR = 5
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_step,
   input  logic [NB_DATA-1:0] i_reg_read,
   input  logic [NB_DATA-1:0] i_ALUresult,
   input  logic [NB_ADDR-1:0] i_reg2write,
   input  logic               i_mem2reg,
   input  logic               i_regWrite,
   input  logic [NB_ADDR-1:0] i_rs_addr,
   input  logic [NB_ADDR-1:0] i_rt_addr,
   output logic [NB_DATA-1:0] o_rs_data,
   output logic [NB_DATA-1:0] o_rt_data,
   output logic [NB_DATA-1:0] o_wb_data,
   output logic [NB_ADDR-1:0] o_wb_reg,
   output logic               o_wb_en,
   input  logic               i_dump_start,
   input  logic               i_dump_ready,
   output logic               o_dump_valid,
   output logic [NB_ADDR-1:0] o_dump_idx,
   output logic [NB_DATA-1:0] o_dump_data,
   output logic               o_dump_busy,
   output logic               o_dump_done
);

   localparam int unsigned NREGS = 2**NB_ADDR;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_e;

   logic [NB_DATA-1:0] regs_q [NREGS];
   logic [NB_DATA-1:0] regs_d [NREGS];

   state_e             state_q, state_d;
   logic [NB_ADDR-1:0] idx_q, idx_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic [NB_ADDR-1:0] next_idx;

   // Register 0 is hardwired zero; a write to the register being read is
   // forwarded in the same cycle it commits.
   function automatic logic [NB_DATA-1:0] bypass_read(
      input logic [NB_ADDR-1:0] addr,
      input logic [NB_DATA-1:0] stored,
      input logic               wb_en,
      input logic [NB_ADDR-1:0] wb_reg,
      input logic [NB_DATA-1:0] wb_data
   );
      if (addr == '0)
         return '0;
      else if (wb_en && (addr == wb_reg))
         return wb_data;
      else
         return stored;
   endfunction

   assign o_wb_data = i_mem2reg ? i_reg_read : i_ALUresult;
   assign o_wb_reg  = i_reg2write;
   assign o_wb_en   = i_regWrite & ~i_step & (i_reg2write != '0);

   assign o_rs_data = bypass_read(i_rs_addr, regs_q[i_rs_addr], o_wb_en, i_reg2write, o_wb_data);
   assign o_rt_data = bypass_read(i_rt_addr, regs_q[i_rt_addr], o_wb_en, i_reg2write, o_wb_data);

   always_comb begin
      regs_d = regs_q;
      if (o_wb_en)
         regs_d[i_reg2write] = o_wb_data;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign next_idx = idx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (i_dump_start) begin
               state_d = SEND;
               idx_d   = '0;
               data_d  = bypass_read('0, regs_q[0], o_wb_en, i_reg2write, o_wb_data);
            end
         end
         SEND: begin
            if (i_dump_ready) begin
               if (idx_q == '1) begin
                  state_d = DONE;
               end else begin
                  idx_d  = next_idx;
                  data_d = bypass_read(next_idx, regs_q[next_idx], o_wb_en, i_reg2write, o_wb_data);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   assign o_dump_valid = (state_q == SEND);
   assign o_dump_busy  = (state_q != IDLE);
   assign o_dump_done  = (state_q == DONE);
   assign o_dump_idx   = idx_q;
   assign o_dump_data  = data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, writeback, bypass,
// guards, and the debug dump engine (full stream, backpressure, live writes).
module tb_wb_regfile;

   localparam int unsigned NB_DATA = 32;
   localparam int unsigned NB_ADDR = 5;

   logic               clk = 1'b0;
   logic               i_reset;
   logic               i_step;
   logic [NB_DATA-1:0] i_reg_read;
   logic [NB_DATA-1:0] i_ALUresult;
   logic [NB_ADDR-1:0] i_reg2write;
   logic               i_mem2reg;
   logic               i_regWrite;
   logic [NB_ADDR-1:0] i_rs_addr;
   logic [NB_ADDR-1:0] i_rt_addr;
   logic [NB_DATA-1:0] o_rs_data;
   logic [NB_DATA-1:0] o_rt_data;
   logic [NB_DATA-1:0] o_wb_data;
   logic [NB_ADDR-1:0] o_wb_reg;
   logic               o_wb_en;
   logic               i_dump_start;
   logic               i_dump_ready;
   logic               o_dump_valid;
   logic [NB_ADDR-1:0] o_dump_idx;
   logic [NB_DATA-1:0] o_dump_data;
   logic               o_dump_busy;
   logic               o_dump_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_regfile #(
      .NB_DATA(NB_DATA),
      .NB_ADDR(NB_ADDR)
   ) dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_step       (i_step),
      .i_reg_read   (i_reg_read),
      .i_ALUresult  (i_ALUresult),
      .i_reg2write  (i_reg2write),
      .i_mem2reg    (i_mem2reg),
      .i_regWrite   (i_regWrite),
      .i_rs_addr    (i_rs_addr),
      .i_rt_addr    (i_rt_addr),
      .o_rs_data    (o_rs_data),
      .o_rt_data    (o_rt_data),
      .o_wb_data    (o_wb_data),
      .o_wb_reg     (o_wb_reg),
      .o_wb_en      (o_wb_en),
      .i_dump_start (i_dump_start),
      .i_dump_ready (i_dump_ready),
      .o_dump_valid (o_dump_valid),
      .o_dump_idx   (o_dump_idx),
      .o_dump_data  (o_dump_data),
      .o_dump_busy  (o_dump_busy),
      .o_dump_done  (o_dump_done)
   );

   task automatic idle_inputs();
      i_step       = 1'b0;
      i_reg_read   = '0;
      i_ALUresult  = '0;
      i_reg2write  = '0;
      i_mem2reg    = 1'b0;
      i_regWrite   = 1'b0;
      i_rs_addr    = '0;
      i_rt_addr    = '0;
      i_dump_start = 1'b0;
      i_dump_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_reset = 1'b0;
      repeat (2) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         i_rs_addr = a[NB_ADDR-1:0];
         i_rt_addr = 5'(31 - a);
         #1;
         n_cmp++;
         if (o_rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rs[%0d]: got %h expected %h", a, o_rs_data, 32'h0);
         end
         n_cmp++;
         if (o_rt_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rt[%0d]: got %h expected %h", 31 - a, o_rt_data, 32'h0);
         end
      end
      n_cmp++;
      if ({o_dump_valid, o_dump_busy, o_dump_done, o_dump_idx, o_dump_data} !== 40'h0) begin
         n_err++;
         $display("FAIL reset_dump: got v%b b%b d%b idx%0d data%h expected all 0",
                  o_dump_valid, o_dump_busy, o_dump_done, o_dump_idx, o_dump_data);
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      i_regWrite  = 1'b1;
      i_mem2reg   = 1'b0;
      i_ALUresult = 32'hDEADBEEF;
      i_reg_read  = 32'h12345678;
      i_reg2write = 5'd5;
      #1;
      n_cmp++;
      if (o_wb_data !== 32'hDEADBEEF || o_wb_en !== 1'b1 || o_wb_reg !== 5'd5) begin
         n_err++;
         $display("FAIL wb_alu_sel: got %h en%b reg%0d expected deadbeef en1 reg5",
                  o_wb_data, o_wb_en, o_wb_reg);
      end
      @(negedge clk);
      i_regWrite = 1'b0;
      i_rs_addr  = 5'd5;
      #1;
      n_cmp++;
      if (o_rs_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL write_alu: got %h expected %h", o_rs_data, 32'hDEADBEEF);
      end
      @(negedge clk);
      i_regWrite = 1'b1;
      i_mem2reg  = 1'b1;
      #1;
      n_cmp++;
      if (o_wb_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL wb_mem_sel: got %h expected %h", o_wb_data, 32'h12345678);
      end
      @(negedge clk);
      i_regWrite = 1'b0;
      #1;
      n_cmp++;
      if (o_rs_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL write_mem: got %h expected %h", o_rs_data, 32'h12345678);
      end
   endtask

   task automatic test_bypass_guards();
      @(negedge clk);
      i_regWrite  = 1'b1;
      i_mem2reg   = 1'b0;
      i_ALUresult = 32'hA5A5A5A5;
      i_reg2write = 5'd9;
      i_rt_addr   = 5'd9;
      i_rs_addr   = 5'd5;
      #1;
      n_cmp++;
      if (o_rt_data !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL bypass_rt: got %h expected %h", o_rt_data, 32'hA5A5A5A5);
      end
      n_cmp++;
      if (o_rs_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL bypass_other_port: got %h expected %h", o_rs_data, 32'h12345678);
      end
      // write to register 0 must be dropped
      @(negedge clk);
      i_ALUresult = 32'hFFFFFFFF;
      i_reg2write = 5'd0;
      i_rs_addr   = 5'd0;
      #1;
      n_cmp++;
      if (o_wb_en !== 1'b0 || o_rs_data !== 32'h0) begin
         n_err++;
         $display("FAIL reg0_same_cycle: got en%b data %h expected en0 data 0", o_wb_en, o_rs_data);
      end
      @(negedge clk);
      i_regWrite = 1'b0;
      #1;
      n_cmp++;
      if (o_rs_data !== 32'h0) begin
         n_err++;
         $display("FAIL reg0_after: got %h expected %h", o_rs_data, 32'h0);
      end
      // halted pipeline suppresses writeback and bypass
      @(negedge clk);
      i_regWrite  = 1'b1;
      i_step      = 1'b1;
      i_ALUresult = 32'h11111111;
      i_reg2write = 5'd9;
      #1;
      n_cmp++;
      if (o_wb_en !== 1'b0 || o_rt_data !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL step_same_cycle: got en%b data %h expected en0 data a5a5a5a5", o_wb_en, o_rt_data);
      end
      @(negedge clk);
      i_regWrite = 1'b0;
      i_step     = 1'b0;
      #1;
      n_cmp++;
      if (o_rt_data !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL step_after: got %h expected %h", o_rt_data, 32'hA5A5A5A5);
      end
   endtask

   task automatic preload_k3();
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         i_regWrite  = 1'b1;
         i_mem2reg   = 1'b0;
         i_reg2write = k[NB_ADDR-1:0];
         i_ALUresult = 32'(k * 3);
      end
      @(negedge clk);
      i_regWrite = 1'b0;
   endtask

   task automatic test_dump_full();
      @(negedge clk);
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         #1;
         n_cmp++;
         if (o_dump_valid !== 1'b1 || o_dump_busy !== 1'b1 || o_dump_done !== 1'b0 ||
             o_dump_idx !== k[NB_ADDR-1:0] || o_dump_data !== 32'(k * 3)) begin
            n_err++;
            $display("FAIL dump_beat[%0d]: got v%b b%b d%b idx%0d data %h expected v1 b1 d0 idx%0d data %h",
                     k, o_dump_valid, o_dump_busy, o_dump_done, o_dump_idx, o_dump_data, k, 32'(k * 3));
         end
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (o_dump_done !== 1'b1 || o_dump_busy !== 1'b1 || o_dump_valid !== 1'b0) begin
         n_err++;
         $display("FAIL dump_done: got d%b b%b v%b expected d1 b1 v0", o_dump_done, o_dump_busy, o_dump_valid);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
         n_err++;
         $display("FAIL dump_idle: got d%b b%b v%b expected d0 b0 v0", o_dump_done, o_dump_busy, o_dump_valid);
      end
      i_dump_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      for (int k = 0; k < 10; k++) @(negedge clk);
      i_dump_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (o_dump_valid !== 1'b1 || o_dump_idx !== 5'd10 || o_dump_data !== 32'd30) begin
            n_err++;
            $display("FAIL hold[%0d]: got v%b idx%0d data %h expected v1 idx10 data %h",
                     c, o_dump_valid, o_dump_idx, o_dump_data, 32'd30);
         end
         i_dump_start = (c == 1);
         @(negedge clk);
      end
      i_dump_start = 1'b0;
      i_dump_ready = 1'b1;
      for (int k = 10; k < 32; k++) begin
         #1;
         n_cmp++;
         if (o_dump_valid !== 1'b1 || o_dump_idx !== k[NB_ADDR-1:0] || o_dump_data !== 32'(k * 3)) begin
            n_err++;
            $display("FAIL bp_beat[%0d]: got v%b idx%0d data %h expected v1 idx%0d data %h",
                     k, o_dump_valid, o_dump_idx, o_dump_data, k, 32'(k * 3));
         end
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_done: got d%b v%b expected d1 v0", o_dump_done, o_dump_valid);
      end
      @(negedge clk);
      i_dump_ready = 1'b0;
   endtask

   task automatic test_write_during_dump();
      logic [31:0] exp;
      @(negedge clk);
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         exp = (k == 5) ? 32'h55 : 32'(k * 3);
         i_regWrite = 1'b0;
         if (k == 4) begin
            i_regWrite  = 1'b1;
            i_reg2write = 5'd5;
            i_ALUresult = 32'h55;
         end else if (k == 5) begin
            i_regWrite  = 1'b1;
            i_reg2write = 5'd3;
            i_ALUresult = 32'h77;
         end
         #1;
         n_cmp++;
         if (o_dump_idx !== k[NB_ADDR-1:0] || o_dump_data !== exp) begin
            n_err++;
            $display("FAIL live_beat[%0d]: got idx%0d data %h expected idx%0d data %h",
                     k, o_dump_idx, o_dump_data, k, exp);
         end
         @(negedge clk);
      end
      i_regWrite   = 1'b0;
      i_dump_ready = 1'b0;
      i_rs_addr    = 5'd3;
      i_rt_addr    = 5'd5;
      #1;
      n_cmp++;
      if (o_rs_data !== 32'h77 || o_rt_data !== 32'h55) begin
         n_err++;
         $display("FAIL live_commit: got r3 %h r5 %h expected r3 00000077 r5 00000055", o_rs_data, o_rt_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_dump();
      logic saw_done;
      @(negedge clk);
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      for (int k = 0; k < 7; k++) @(negedge clk);
      #1;
      n_cmp++;
      if (o_dump_idx !== 5'd7 || o_dump_valid !== 1'b1) begin
         n_err++;
         $display("FAIL pre_abort: got idx%0d v%b expected idx7 v1", o_dump_idx, o_dump_valid);
      end
      i_reset = 1'b0;
      #1;
      n_cmp++;
      if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_idx !== 5'd0 ||
          o_dump_done !== 1'b0 || o_dump_data !== 32'h0) begin
         n_err++;
         $display("FAIL abort: got v%b b%b d%b idx%0d data %h expected all 0",
                  o_dump_valid, o_dump_busy, o_dump_done, o_dump_idx, o_dump_data);
      end
      @(negedge clk);
      i_reset = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_done: got activity %b expected %b", saw_done, 1'b0);
      end
      i_rs_addr = 5'd5;
      #1;
      n_cmp++;
      if (o_rs_data !== 32'h0) begin
         n_err++;
         $display("FAIL abort_regs_cleared: got %h expected %h", o_rs_data, 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_bypass_guards();
      preload_k3();
      test_dump_full();
      test_backpressure();
      preload_k3();
      test_write_during_dump();
      preload_k3();
      test_reset_mid_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. It selects the writeback value, commits it to a 2**NB_ADDR-entry general-purpose register bank, and serves two decode-stage read ports with write-through bypass. It also exposes the writeback bus to the forwarding unit. A handshaked debug dump engine streams all registers out sequentially for the debug/UART unit.

Parameters:
NB_DATA, 32, data width of each register
NB_ADDR, 5, register address width; NREGS = 2**NB_ADDR

Ports:
clk  in  1  system clock, all state updates on rising edge
i_reset  in  1  asynchronous active-low reset
i_step  in  1  pipeline hold; 1 = halt, writeback suppressed
i_reg_read  in  NB_DATA  data-memory read value from MEM/WB
i_ALUresult  in  NB_DATA  ALU result from MEM/WB
i_reg2write  in  NB_ADDR  destination register
i_mem2reg  in  1  1 = write i_reg_read, 0 = write i_ALUresult
i_regWrite  in  1  writeback enable
i_rs_addr  in  NB_ADDR  read port A address
i_rt_addr  in  NB_ADDR  read port B address
o_rs_data  out  NB_DATA  read port A data (combinational)
o_rt_data  out  NB_DATA  read port B data (combinational)
o_wb_data  out  NB_DATA  selected writeback value (combinational)
o_wb_reg  out  NB_ADDR  = i_reg2write
o_wb_en  out  1  effective write enable (combinational)
i_dump_start  in  1  one-cycle request to start register dump
i_dump_ready  in  1  consumer accepts current dump beat
o_dump_valid  out  1  dump beat valid
o_dump_idx  out  NB_ADDR  index of current beat
o_dump_data  out  NB_DATA  register value of current beat
o_dump_busy  out  1  dump in progress
o_dump_done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (asynchronous, i_reset=0): all registers 0; FSM IDLE; o_dump_valid/o_dump_busy/o_dump_done=0; o_dump_idx=0; o_dump_data=0. Reset mid-dump aborts immediately; no done pulse.
- o_wb_data = i_mem2reg ? i_reg_read : i_ALUresult.
- o_wb_en = i_regWrite & !i_step & (i_reg2write != 0).
- Write: rising edge with o_wb_en=1 stores o_wb_data into reg[i_reg2write]. Register 0 reads 0 always and is never written.
- Read ports: addr 0 -> 0. addr == i_reg2write with o_wb_en=1 -> o_wb_data (same-cycle bypass). Otherwise reg[addr].
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: i_dump_start=1 -> SEND; idx=0; o_dump_data captures the bypassed value of reg[0] (i.e. 0); valid=1; busy=1.
  - SEND: valid=1. o_dump_idx and o_dump_data are stable while i_dump_ready=0.
    - On valid&ready with idx < NREGS-1: idx increments. o_dump_data captures the bypassed value of reg[idx+1], so a write to that register in the same cycle is seen.
    - On valid&ready with idx = NREGS-1: -> DONE; valid=0.
  - DONE: o_dump_done=1 for exactly one cycle; busy=1; -> IDLE next cycle.
- i_dump_start while busy (SEND or DONE) is ignored.
- Writeback continues during a dump. Already-captured beats are not updated; later beats reflect writes committed before their capture.
- Throughput: one beat per cycle with ready held high. A full dump is NREGS beats, then 1 done cycle.
- i_step has no effect on the dump FSM.

Test Plan:
- Reset then read all addresses -> every o_rs_data/o_rt_data = 0. Assert reset mid-dump at idx=7 -> valid, busy and idx return to 0 at once; no done pulse.
- Write reg5: i_regWrite=1, i_mem2reg=0, i_ALUresult=0xDEADBEEF, i_reg2write=5.
  - Next cycle, i_rs_addr=5 -> 0xDEADBEEF.
  - Repeat with i_mem2reg=1, i_reg_read=0x12345678 -> reg5=0x12345678.
- Bypass and guards:
  - Same cycle as a write of 0xA5A5A5A5 to reg9, i_rt_addr=9 -> o_rt_data=0xA5A5A5A5.
  - Write to reg0 with 0xFFFFFFFF -> reg0 still reads 0.
  - Same write with i_step=1 -> o_wb_en=0; reg9 unchanged.
- Dump with ready always 1, reg k preloaded with k*3:
  - 32 consecutive beats, idx 0..31, data 0,3,...,93.
  - o_dump_done pulses one cycle after beat 31; busy clears the cycle after.
- Backpressure: ready low for 4 cycles at idx=10 -> idx and data held at 10/30. A second i_dump_start during the dump is ignored; the dump completes normally.
- Write during dump: while beat 4 is presented with ready=1, write 0x55 to reg5 -> beat 5 data=0x55. Writing reg3 afterwards does not alter any already-sent beat.
